// File: rtl/if_neuron_sequencer_if.sv
// Bundle of every non-clock signal between the IF neuron sequencer and its
// surroundings: timestep scheduler (start/done/busy), activation stream
// (in_valid/in_ready), membrane RAM (read/write strobes and addresses),
// neuron datapath (load/input/output enables, arithmetic mode, results) and
// the spike collector (spike_valid/spike_idx/spike).
//   master : the sequencer itself
//   slave  : everything around it (scheduler, RAM, neuron, collector)
interface if_neuron_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              start;
  logic              arithm_mode;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              nrn_load_en;
  logic              nrn_input_valid;
  logic              nrn_output_en;
  logic              nrn_arithm;
  logic [DATA_W-1:0] nrn_out_mem_vol;
  logic              nrn_spike_out;
  logic              spike_valid;
  logic [ADDR_W-1:0] spike_idx;
  logic              spike;

  modport master (
    input  start, arithm_mode, in_valid, nrn_out_mem_vol, nrn_spike_out,
    output busy, done, in_ready,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output nrn_load_en, nrn_input_valid, nrn_output_en, nrn_arithm,
    output spike_valid, spike_idx, spike
  );

  modport slave (
    output start, arithm_mode, in_valid, nrn_out_mem_vol, nrn_spike_out,
    input  busy, done, in_ready,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  nrn_load_en, nrn_input_valid, nrn_output_en, nrn_arithm,
    input  spike_valid, spike_idx, spike
  );
endinterface

// File: rtl/if_neuron_sequencer.sv
// Time-multiplexing controller for one integrate-and-fire neuron datapath.
// Each start walks NUM_NEURONS neurons in index order: read membrane voltage
// (RD), load it into the neuron (LOAD), stream FAN_IN activation/weight pairs
// (ACC), fire (FIRE), then write the result back and report the spike (WB).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high; aborts a running timestep
//   bus  master side of if_neuron_sequencer_if (scheduler, RAM, neuron and
//        spike collector signals)
module if_neuron_sequencer #(
  parameter int NUM_NEURONS = 16,
  parameter int FAN_IN      = 8,
  parameter int ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input logic                   clk,
  input logic                   rst,
  if_neuron_sequencer_if.master bus
);
  localparam int CNT_W = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FAN_IN - 1);

  typedef enum logic [2:0] {IDLE, RD, LOAD, ACC, FIRE, WB, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic              busy_r;
  logic              done_r;
  logic              rd_en_r;
  logic              wr_en_r;
  logic              load_r;
  logic              acc_r;
  logic              fire_r;
  logic              arithm_r;
  logic              accept;

  // acc_r is the registered "in ACC" flag, so in_ready is glitch-free;
  // only the acceptance itself is combinational.
  assign accept = acc_r & bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rd_en_r  <= 1'b0;
      wr_en_r  <= 1'b0;
      load_r   <= 1'b0;
      acc_r    <= 1'b0;
      fire_r   <= 1'b0;
      arithm_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RD;
            busy_r   <= 1'b1;
            rd_en_r  <= 1'b1;
            arithm_r <= bus.arithm_mode;
          end
        end
        RD: begin
          state   <= LOAD;
          rd_en_r <= 1'b0;
          load_r  <= 1'b1;
        end
        LOAD: begin
          state  <= ACC;
          load_r <= 1'b0;
          acc_r  <= 1'b1;
        end
        ACC: begin
          // No timeout: a stalled stream just parks here; the neuron holds
          // its accumulator because input_valid stays low.
          if (accept) begin
            if (cnt == LAST_CNT) begin
              state  <= FIRE;
              cnt    <= '0;
              acc_r  <= 1'b0;
              fire_r <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FIRE: begin
          state   <= WB;
          fire_r  <= 1'b0;
          wr_en_r <= 1'b1;
        end
        WB: begin
          wr_en_r <= 1'b0;
          cnt     <= '0;
          if (idx == LAST_IDX) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            state   <= RD;
            idx     <= idx + ADDR_W'(1);
            rd_en_r <= 1'b1;
          end
        end
        DONE: begin
          // A start arriving here is dropped: we only look at start in IDLE.
          state  <= IDLE;
          done_r <= 1'b0;
          idx    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.in_ready        = acc_r;
  assign bus.nrn_input_valid = accept;
  assign bus.mem_rd_en       = rd_en_r;
  assign bus.mem_rd_addr     = idx;
  assign bus.nrn_load_en     = load_r;
  assign bus.nrn_output_en   = fire_r;
  assign bus.nrn_arithm      = arithm_r;
  // The neuron registers its results on the FIRE edge, so during WB they
  // are already stable and can be forwarded straight to RAM and collector.
  assign bus.mem_wr_en       = wr_en_r;
  assign bus.mem_wr_addr     = idx;
  assign bus.mem_wr_data     = bus.nrn_out_mem_vol;
  assign bus.spike_valid     = wr_en_r;
  assign bus.spike_idx       = idx;
  assign bus.spike           = wr_en_r & bus.nrn_spike_out;
endmodule

// File: tb/tb_if_neuron_sequencer.sv
module tb_if_neuron_sequencer;
  localparam int N    = 4;
  localparam int F    = 8;
  localparam int AW   = 2;
  localparam int LAT0 = N * (F + 4) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_neuron_sequencer_if #(.ADDR_W(AW), .DATA_W(16)) ifa ();
  if_neuron_sequencer_if #(.ADDR_W(1),  .DATA_W(16)) ifb ();

  if_neuron_sequencer #(.NUM_NEURONS(N), .FAN_IN(F)) u0 (.clk(clk), .rst(rst), .bus(ifa));
  if_neuron_sequencer #(.NUM_NEURONS(1), .FAN_IN(1)) u1 (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- membrane RAM and IF neuron (threshold 127, reset by subtraction)
  int   ram [N];
  int   pv [N][F];
  int   rd_q = 0;
  int   cur = 0;
  int   vm = 0;
  int   pulses = 0;
  int   out_q = 0;
  logic spk_q = 1'b0;
  logic poke_en = 1'b0;
  int   poke_addr = 0;
  int   poke_val = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ram[i] <= 0;
    end else begin
      if (poke_en) ram[poke_addr] <= poke_val;
      if (ifa.mem_wr_en) ram[int'(ifa.mem_wr_addr)] <= int'(ifa.mem_wr_data);
    end
    if (ifa.mem_rd_en) begin
      rd_q <= ram[int'(ifa.mem_rd_addr)];
      cur  <= int'(ifa.mem_rd_addr);
    end
    if (ifa.nrn_load_en) begin
      vm     <= rd_q;
      pulses <= 0;
    end else if (ifa.nrn_input_valid) begin
      vm     <= vm + ((pulses < F) ? pv[cur][pulses] : 0);
      pulses <= pulses + 1;
    end
    if (ifa.nrn_output_en) begin
      out_q <= (vm >= 127) ? vm - 127 : vm;
      spk_q <= (vm >= 127);
    end
  end

  assign ifa.nrn_out_mem_vol = 16'(out_q);
  assign ifa.nrn_spike_out   = spk_q;
  assign ifb.nrn_out_mem_vol = 16'h0055;
  assign ifb.nrn_spike_out   = 1'b1;

  // ---------------- timestep model + per-cycle compare
  typedef struct {int addr; int data; int spk;} wr_t;
  wr_t exp_q[$];
  bit  m_active = 1'b0;
  int  m_cyc = 0, m_lat = 0, m_arith = 0, exp_rd = 0;
  int  stall_n = 0;
  int  wr_cnt = 0, done_cnt = 0;
  int  wr_seen [N];
  int  sp_seen [N];
  int  wr_hits [N];

  initial begin
    for (int i = 0; i < N; i++) begin wr_seen[i] = -1; sp_seen[i] = -1; wr_hits[i] = 0; end
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_active = 1'b0;
        exp_q.delete();
        chk("rst_outs", int'({ifa.busy, ifa.done, ifa.in_ready, ifa.mem_rd_en, ifa.mem_wr_en,
                              ifa.nrn_load_en, ifa.nrn_input_valid, ifa.nrn_output_en,
                              ifa.nrn_arithm, ifa.spike_valid, ifa.spike}), 0);
        chk("rst_addrs", int'({ifa.mem_rd_addr, ifa.mem_wr_addr, ifa.spike_idx}), 0);
      end else begin
        if (m_active) begin
          if (m_cyc == m_lat) m_active = 1'b0;
          else m_cyc++;
        end else if (ifa.start) begin
          m_active = 1'b1;
          m_cyc    = 1;
          m_lat    = LAT0 + stall_n;
          m_arith  = int'(ifa.arithm_mode);
          exp_rd   = 0;
          exp_q.delete();
          for (int i = 0; i < N; i++) begin
            wr_t e;
            int  s;
            s = ram[i];
            for (int j = 0; j < F; j++) s += pv[i][j];
            e.addr = i;
            e.data = (s >= 127) ? s - 127 : s;
            e.spk  = (s >= 127) ? 1 : 0;
            exp_q.push_back(e);
          end
        end
        chk("busy", int'(ifa.busy), int'(m_active && m_cyc < m_lat));
        chk("done", int'(ifa.done), int'(m_active && m_cyc == m_lat));
        chk("excl", int'((int'(ifa.nrn_load_en) + int'(ifa.nrn_input_valid)
                          + int'(ifa.nrn_output_en)) <= 1), 1);
        if (m_active && m_cyc < m_lat) chk("arithm", int'(ifa.nrn_arithm), m_arith);
        if (ifa.mem_rd_en) begin
          chk("rd_addr", int'(ifa.mem_rd_addr), exp_rd);
          exp_rd++;
        end
        if (ifa.nrn_output_en) chk("pulses_per_neuron", pulses, F);
        chk("spike_valid", int'(ifa.spike_valid), int'(ifa.mem_wr_en));
        if (ifa.mem_wr_en) begin
          wr_cnt++;
          wr_hits[int'(ifa.mem_wr_addr)]++;
          wr_seen[int'(ifa.mem_wr_addr)] = int'(ifa.mem_wr_data);
          sp_seen[int'(ifa.mem_wr_addr)] = int'(ifa.spike);
          chk("wr_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", int'(ifa.mem_wr_addr), e.addr);
            chk("wr_data", int'(ifa.mem_wr_data), e.data);
            chk("spike", int'(ifa.spike), e.spk);
            chk("spike_idx", int'(ifa.spike_idx), e.addr);
          end
        end
        if (ifa.done) begin
          done_cnt++;
          chk("done_queue_empty", exp_q.size(), 0);
        end
      end
    end
  end

  // ---------------- stimulus
  task automatic poke(input int a, input int v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Runs one timestep on u0; returns cycles from start edge to the done cycle.
  task automatic run_ts(input bit do_stall, input bit extra_starts, output int c);
    bit pending;
    int hold;
    pending = do_stall;
    hold = 0;
    stall_n = do_stall ? 3 : 0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    c = 1;
    chk("first_rd_en", int'(ifa.mem_rd_en), 1);
    chk("first_rd_addr", int'(ifa.mem_rd_addr), 0);
    while (!ifa.done && c < 2000) begin
      if (pending && ifa.in_ready && pulses == 4) begin
        ifa.in_valid = 1'b0; hold = 3; pending = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) ifa.in_valid = 1'b1;
      end
      if (extra_starts) ifa.start = (c == 10);
      @(negedge clk);
      c++;
    end
    chk("done_seen", int'(ifa.done), 1);
    if (extra_starts) begin
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
    end
  endtask

  initial begin
    int  c;
    int  w0, d0, h2;
    logic [5:0] e;
    ifa.start = 1'b0; ifa.arithm_mode = 1'b0; ifa.in_valid = 1'b1;
    ifb.start = 1'b0; ifb.arithm_mode = 1'b0; ifb.in_valid = 1'b1;
    for (int i = 0; i < N; i++) for (int j = 0; j < F; j++) pv[i][j] = 16;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(ifa.busy), 0);
    chk("reset_in_ready", int'(ifa.in_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all neurons 0 + 8*16 = 128 -> spike, residue 1, done at cycle 49
    run_ts(1'b0, 1'b0, c);
    chk("t1_done_cycle", c, 49);
    for (int i = 0; i < N; i++) begin
      chk("t1_wr_data", wr_seen[i], 1);
      chk("t1_spike", sp_seen[i], 1);
    end

    // 2: neuron 2 at 120 plus 6 -> 126 no spike; plus 7 -> 127 spike, residue 0
    poke(2, 120);
    for (int j = 0; j < F; j++) pv[2][j] = (j < 6) ? 1 : 0;
    run_ts(1'b0, 1'b0, c);
    chk("t2a_wr_data", wr_seen[2], 126);
    chk("t2a_spike", sp_seen[2], 0);
    poke(2, 120);
    pv[2][6] = 1;
    run_ts(1'b0, 1'b0, c);
    chk("t2b_wr_data", wr_seen[2], 0);
    chk("t2b_spike", sp_seen[2], 1);

    // 3: three stall cycles mid-ACC push done out by exactly three cycles
    run_ts(1'b1, 1'b0, c);
    chk("t3_done_cycle", c, 52);

    // 4: start while busy and on the done cycle is ignored
    w0 = wr_cnt;
    run_ts(1'b0, 1'b1, c);
    repeat (30) @(negedge clk);
    chk("t4_writes", wr_cnt - w0, 4);
    chk("t4_idle_busy", int'(ifa.busy), 0);

    // 5: reset during neuron 2 ACC aborts the timestep
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    c = 0;
    while (!(ifa.in_ready && cur == 2 && pulses == 3) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t5_reached_n2", int'(ifa.in_ready && cur == 2), 1);
    h2 = wr_hits[2];
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", int'({ifa.busy, ifa.in_ready, ifa.mem_rd_en, ifa.mem_wr_en,
                             ifa.nrn_load_en, ifa.nrn_input_valid, ifa.nrn_output_en}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_wr_idx2", wr_hits[2], h2);
    chk("t5_no_done", done_cnt, d0);
    run_ts(1'b0, 1'b0, c);
    chk("t5_restart_cycle", c, 49);

    // 6: N=1, F=1, arithm_mode=1: RD, LOAD, ACC, FIRE, WB, DONE
    ifb.arithm_mode = 1'b1;
    @(negedge clk);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      e = 6'b100000 >> (k - 1);
      chk("t6_seq", int'({ifb.mem_rd_en, ifb.nrn_load_en, ifb.nrn_input_valid,
                          ifb.nrn_output_en, ifb.mem_wr_en, ifb.done}), int'(e));
      chk("t6_busy", int'(ifb.busy), int'(k <= 5));
      if (k <= 5) chk("t6_arithm", int'(ifb.nrn_arithm), 1);
      if (k == 5) begin
        chk("t6_wr_data", int'(ifb.mem_wr_data), 85);
        chk("t6_spike", int'({ifb.spike_valid, ifb.spike}), 3);
      end
      @(negedge clk);
    end
    chk("t6_idle", int'({ifb.busy, ifb.done}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
